reg_file_2r1w: RTL and testbench



---
 rtl/reg_file_pkg.sv | 6 +
 rtl/reg_file_clr_seq.sv | 41 ++++
 rtl/reg_file_2r1w.sv | 65 ++++++
 tb/tb_reg_file_2r1w.sv | 137 +++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and default widths for the 2R1W register file.
package reg_file_pkg;
   typedef enum logic {CLEAR, READY} rf_state_t;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: CLEAR/READY sequencer that sweeps every address with a zero write.
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 32
) (
   input  logic              clkout,
   input  logic              rst_n,
   input  logic              clr,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready
);
   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              last;

   assign last = cnt_q == ADDR_W'(DEPTH - 1);

   always_ff @(posedge clkout or negedge rst_n)
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end

   // clr only matters in READY; the counter parks at 0 outside the sweep
   always_comb begin
      state_d = state_q == CLEAR ? (last ? READY : CLEAR) : (clr ? CLEAR : READY);
      cnt_d   = state_q == CLEAR && !last ? cnt_q + ADDR_W'(1) : '0;
   end

   always_comb begin
      clr_we   = state_q == CLEAR;
      clr_addr = cnt_q;
      ready    = state_q == READY;
   end
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two-read one-write register file with write bypass, optional
// hardwired zero register and a hardware clear sweep after reset or on request.
module reg_file_2r1w
   import reg_file_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DEPTH   = 32,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic              clkout,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              ready
);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d, wdata;
   logic [ADDR_W-1:0] clr_addr, waddr;
   logic              clr_we, user_we, we, zero_a, zero_b;

   reg_file_clr_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_seq (
      .clkout   (clkout),
      .rst_n    (rst_n),
      .clr      (clr),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready    (ready)
   );

   // a clr request discards the user write issued alongside it, bypass included
   always_comb begin
      user_we = ready && wr_en && !clr && {1'b0, wr_addr} < DEPTH_L && !(R0_ZERO && wr_addr == '0);
      we      = clr_we || user_we;
      waddr   = clr_we ? clr_addr : wr_addr;
      wdata   = clr_we ? '0 : wr_data;
      zero_a  = !ready || {1'b0, rd_addr_a} >= DEPTH_L || (R0_ZERO && rd_addr_a == '0);
      zero_b  = !ready || {1'b0, rd_addr_b} >= DEPTH_L || (R0_ZERO && rd_addr_b == '0);
      rd_a_d  = zero_a ? '0 : (user_we && wr_addr == rd_addr_a) ? wr_data : mem[rd_addr_a];
      rd_b_d  = zero_b ? '0 : (user_we && wr_addr == rd_addr_b) ? wr_data : mem[rd_addr_b];
   end

   always_ff @(posedge clkout)
      if (we) mem[waddr] <= wdata;

   always_ff @(posedge clkout or negedge rst_n)
      if (!rst_n) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end

   assign rd_data_a = rd_a_q;
   assign rd_data_b = rd_b_q;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed checks of clear sweep, reads, bypass, r0 and reset restart.
module tb_reg_file_2r1w;
   logic        clkout = 1'b0;
   logic        rst_n = 1'b0, clr = 1'b0, wr_en = 1'b0, ready;
   logic [4:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
   logic [31:0] wr_data = '0, rd_data_a, rd_data_b;
   int          passed = 0, total = 0;

   reg_file_2r1w dut (
      .clkout    (clkout),
      .rst_n     (rst_n),
      .clr       (clr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .ready     (ready)
   );

   always #5 clkout = ~clkout;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clkout);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   // ready must stay low for 31 edges and rise on the 32nd, reads zero throughout
   task automatic sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         step();
         chk({tag, "_ready"}, 32'(ready), 32'(i == 31));
         chk({tag, "_rda"}, rd_data_a, 32'h0);
         chk({tag, "_rdb"}, rd_data_b, 32'h0);
      end
   endtask

   task automatic read_all_zero(input string tag);
      for (int a = 0; a < 32; a++) begin
         rd_addr_a = 5'(a); rd_addr_b = 5'(31 - a);
         step();
         chk({tag, "_a"}, rd_data_a, 32'h0);
         chk({tag, "_b"}, rd_data_b, 32'h0);
      end
   endtask

   initial begin
      step();
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_rda", rd_data_a, 32'h0);
      chk("rst_rdb", rd_data_b, 32'h0);
      rst_n = 1'b1;
      sweep("init");
      read_all_zero("init_read");

      rd_addr_a = 5'd6; rd_addr_b = 5'd6;
      wr(5'd5, 32'hDEADBEEF);
      rd_addr_a = 5'd5; rd_addr_b = 5'd5;
      step();
      chk("arr_a5", rd_data_a, 32'hDEADBEEF);
      chk("arr_b5", rd_data_b, 32'hDEADBEEF);

      wr(5'd3, 32'hA5A5A5A5);
      rd_addr_a = 5'd7; rd_addr_b = 5'd3;
      wr(5'd7, 32'h12345678);
      chk("byp_a7", rd_data_a, 32'h12345678);
      chk("byp_b3", rd_data_b, 32'hA5A5A5A5);
      step();
      chk("arr_a7", rd_data_a, 32'h12345678);

      rd_addr_a = 5'd0; rd_addr_b = 5'd0;
      wr(5'd0, 32'hFFFFFFFF);
      chk("r0_byp_a", rd_data_a, 32'h0);
      chk("r0_byp_b", rd_data_b, 32'h0);
      step();
      chk("r0_later", rd_data_a, 32'h0);

      for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
      rd_addr_a = 5'd4; rd_addr_b = 5'd31;
      step();
      chk("fill_a4", rd_data_a, 32'd4);
      chk("fill_b31", rd_data_b, 32'd31);

      rd_addr_a = 5'd9; rd_addr_b = 5'd4;
      clr = 1'b1;
      wr(5'd4, 32'h55);
      clr = 1'b0;
      chk("clr_rd_a9", rd_data_a, 32'd9);
      chk("clr_rd_b4", rd_data_b, 32'd4);
      chk("clr_ready", 32'(ready), 32'h0);
      // a second clr and a write mid-sweep must both be ignored
      for (int i = 0; i < 32; i++) begin
         clr = i == 5; wr_en = i == 6; wr_addr = 5'd8; wr_data = 32'hBAD0BAD0;
         step();
         chk("clr_sweep_ready", 32'(ready), 32'(i == 31));
         chk("clr_sweep_rda", rd_data_a, 32'h0);
      end
      clr = 1'b0; wr_en = 1'b0;
      read_all_zero("clr_read");

      rd_addr_a = 5'd6; rd_addr_b = 5'd2;
      wr(5'd6, 32'h77);
      step();
      chk("pre_rst_a6", rd_data_a, 32'h77);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_rda", rd_data_a, 32'h0);
      chk("async_rst_ready", 32'(ready), 32'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("mid_ready", 32'(ready), 32'h0);
      end
      #2 rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      sweep("restart");
      step();
      chk("restart_a6", rd_data_a, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
